// File: rtl/alu_nibble_seq_pkg.sv
// alu_nibble_seq_pkg: shared FSM state encodings and slice op codes
package alu_nibble_seq_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;
endpackage

// File: rtl/alu_4bit_struct.sv
// alu_4bit_struct: combinational 4-bit ALU slice; carry out is only meaningful for ADD
module alu_4bit_struct
    import alu_nibble_seq_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [1:0] s,
    input  logic       cin,
    output logic [3:0] f,
    output logic       cout
);
    logic [4:0] sum;
    always_comb begin
        sum  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        f    = s == OP_ADD ? sum[3:0] : s == OP_XOR ? a ^ b : s == OP_OR ? a | b : a & b;
        cout = s == OP_ADD && sum[4];
    end
endmodule

// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq: WIDTH-bit ALU built by running one 4-bit slice LSB-first over NIB cycles
module alu_nibble_seq
    import alu_nibble_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       s,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             busy
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = $clog2(NIB);

    state_t           st;
    logic [WIDTH-1:0] a_q, b_q;
    logic [1:0]       s_q;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic [3:0]       sf;
    logic             sc;
    logic             last;

    assign last = cnt == CW'(NIB - 1);

    alu_4bit_struct u_slice (
        .a    (a_q[{cnt, 2'b00} +: 4]),
        .b    (b_q[{cnt, 2'b00} +: 4]),
        .s    (s_q),
        .cin  (carry_q),
        .f    (sf),
        .cout (sc)
    );

    // Handshake outputs are registered alongside the state so they change only on transitions
    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            f         <= '0;
            cout      <= 1'b0;
            cnt       <= '0;
            carry_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            s_q       <= '0;
        end else begin
            case (st)
                ST_IDLE: if (in_valid) begin
                    a_q      <= a;
                    b_q      <= b;
                    s_q      <= s;
                    carry_q  <= cin;
                    cnt      <= '0;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                    st       <= ST_RUN;
                end
                ST_RUN: begin
                    f[{cnt, 2'b00} +: 4] <= sf;
                    carry_q              <= sc;
                    cnt                  <= last ? '0 : cnt + 1'b1;
                    if (last) begin
                        cout      <= sc;
                        out_valid <= 1'b1;
                        st        <= ST_DONE;
                    end
                end
                ST_DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    st        <= ST_IDLE;
                end
                default: st <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_nibble_seq.sv
// tb_alu_nibble_seq: directed checks of the nibble-serial ALU controller
module tb_alu_nibble_seq;
    import alu_nibble_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, cin;
    logic [15:0] a, b;
    logic [1:0]  s;
    logic        in_ready, out_valid, cout, busy;
    logic [15:0] f;
    int          total = 0;
    int          bad = 0;
    int          lat;

    alu_nibble_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .s         (s),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Accept one operand bundle, optionally scramble inputs mid-RUN, wait for out_valid
    task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_, input logic [1:0] ts,
                            input logic tc, input bit scramble, output int l);
        @(negedge clk);
        chk("ready_before_accept", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        a = ta;
        b = tb_;
        s = ts;
        cin = tc;
        @(posedge clk);
        l = 1;
        @(negedge clk);
        in_valid = 1'b0;
        if (scramble) begin
            a = 16'hFFFF;
            b = 16'h5A5A;
            s = OP_XOR;
            cin = 1'b1;
        end
        while (!out_valid && l < 20) begin
            @(posedge clk);
            l++;
            @(negedge clk);
        end
    endtask

    task automatic consume;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_drop", {31'b0, out_valid}, 32'd0);
        chk("ready_back", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b0;
        a = 16'h1111;
        b = 16'h2222;
        s = OP_ADD;
        cin = 1'b0;
        // T1 reset with in_valid asserted
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", {12'b0, in_ready, out_valid, busy, cout, f}, {12'b0, 4'b1000, 16'h0000});
        rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_no_accept", {31'b0, busy}, 32'd0);
        // T2 add with latency check
        start_op(16'h1234, 16'h0FFF, OP_ADD, 1'b0, 1'b0, lat);
        chk("t2_latency", lat, 32'd5);
        chk("t2_result", {15'b0, cout, f}, {15'b0, 1'b0, 16'h2233});
        chk("t2_busy", {30'b0, busy, in_ready}, 32'b10);
        consume();
        // T3 carry ripples through all nibbles
        start_op(16'hFFFF, 16'h0000, OP_ADD, 1'b1, 1'b0, lat);
        chk("t3_latency", lat, 32'd5);
        chk("t3_result", {15'b0, cout, f}, {15'b0, 1'b1, 16'h0000});
        // T4 backpressure for 10 cycles with in_valid pulses
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a = 16'hABCD;
            @(posedge clk);
            @(negedge clk);
            chk("t4_hold", {13'b0, out_valid, in_ready, cout, f}, {13'b0, 3'b101, 16'h0000});
        end
        in_valid = 1'b0;
        consume();
        // T5 operand changes mid-RUN must not affect the result
        start_op(16'h0001, 16'h0001, OP_ADD, 1'b0, 1'b1, lat);
        chk("t5_result", {15'b0, cout, f}, {15'b0, 1'b0, 16'h0002});
        consume();
        // Logic ops exercise the slice mux; cin must not leak into cout
        start_op(16'h1234, 16'h0FFF, OP_AND, 1'b1, 1'b0, lat);
        chk("and_result", {15'b0, cout, f}, {15'b0, 1'b0, 16'h0234});
        consume();
        start_op(16'h1234, 16'h0F0F, OP_OR, 1'b0, 1'b0, lat);
        chk("or_result", {15'b0, cout, f}, {15'b0, 1'b0, 16'h1F3F});
        consume();
        start_op(16'h1234, 16'hFFFF, OP_XOR, 1'b1, 1'b0, lat);
        chk("xor_result", {15'b0, cout, f}, {15'b0, 1'b0, 16'hEDCB});
        consume();
        // T6 reset during the 3rd RUN cycle
        @(negedge clk);
        in_valid = 1'b1;
        a = 16'hFFFF;
        b = 16'hFFFF;
        s = OP_ADD;
        cin = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("t6_abort", {12'b0, in_ready, out_valid, busy, cout, f}, {12'b0, 4'b1000, 16'h0000});
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("t6_no_valid", {30'b0, out_valid, busy}, 32'd0);
        end
        start_op(16'h00FF, 16'h0001, OP_ADD, 1'b0, 1'b0, lat);
        chk("t6_latency", lat, 32'd5);
        chk("t6_result", {15'b0, cout, f}, {15'b0, 1'b0, 16'h0100});
        consume();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
